// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - CPU/DMA round-robin sequencer for the single data-memory port
module data_mem_arbiter #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [1:0]        cpu_size,
  output logic              cpu_ready,
  output logic              cpu_err,
  output logic [31:0]       cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [31:0]       dma_addr,
  input  logic [31:0]       dma_wdata,
  output logic              dma_done,
  output logic [31:0]       dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_en,
  output logic              mem_rd,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RDWAIT,
    S_DONE
  } state_t;

  state_t      state;
  logic        last;      // 1 = DMA was granted last
  logic        gnt_dma;   // requester owning the current transaction
  logic        is_read;
  logic        is_err;

  logic [3:0]  cpu_en_enc;
  logic [31:0] cpu_wd_enc;
  logic        cpu_bad;
  logic        pick_dma;

  // Address bits outside the word-address window are intentionally ignored
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], dma_addr[31:ADDR_W+2], dma_addr[1:0]};

  // Byte-lane encoding of a CPU store; lane 0 is the most significant byte
  always_comb begin
    cpu_en_enc = 4'b0000;
    cpu_wd_enc = 32'h0;
    cpu_bad    = 1'b0;
    case (cpu_size)
      2'b00: begin
        cpu_en_enc = 4'b1111;
        cpu_wd_enc = cpu_wdata;
      end
      2'b01: begin
        case (cpu_addr[1:0])
          2'b00: begin
            cpu_en_enc = 4'b0011;
            cpu_wd_enc = {cpu_wdata[15:0], 16'h0};
          end
          2'b10: begin
            cpu_en_enc = 4'b1100;
            cpu_wd_enc = {16'h0, cpu_wdata[15:0]};
          end
          default: cpu_bad = 1'b1;
        endcase
      end
      2'b10: begin
        case (cpu_addr[1:0])
          2'b00: begin
            cpu_en_enc = 4'b0001;
            cpu_wd_enc = {cpu_wdata[7:0], 24'h0};
          end
          2'b01: begin
            cpu_en_enc = 4'b0010;
            cpu_wd_enc = {8'h0, cpu_wdata[7:0], 16'h0};
          end
          2'b10: begin
            cpu_en_enc = 4'b0100;
            cpu_wd_enc = {16'h0, cpu_wdata[7:0], 8'h0};
          end
          default: begin
            cpu_en_enc = 4'b1000;
            cpu_wd_enc = {24'h0, cpu_wdata[7:0]};
          end
        endcase
      end
      default: cpu_bad = 1'b1;
    endcase
  end

  // Round-robin choice: on a tie the requester not granted last time wins
  always_comb begin
    pick_dma = dma_req && (!cpu_req || !last);
  end

  // Sequencer: grant, drive memory port for one cycle, optional read wait, completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      last      <= 1'b1;
      gnt_dma   <= 1'b0;
      is_read   <= 1'b0;
      is_err    <= 1'b0;
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= 32'h0;
      dma_done  <= 1'b0;
      dma_rdata <= 32'h0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      mem_en    <= 4'b0000;
      mem_rd    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_req || dma_req) begin
            gnt_dma <= pick_dma;
            last    <= pick_dma;
            state   <= S_ACCESS;
            if (pick_dma) begin
              is_err    <= 1'b0;
              is_read   <= !dma_we;
              mem_addr  <= dma_addr[ADDR_W+1:2];
              mem_rd    <= !dma_we;
              mem_en    <= dma_we ? 4'b1111 : 4'b0000;
              mem_wdata <= dma_we ? dma_wdata : 32'h0;
            end else begin
              is_err    <= cpu_bad;
              is_read   <= !cpu_we;
              mem_addr  <= cpu_addr[ADDR_W+1:2];
              mem_rd    <= !cpu_we && !cpu_bad;
              mem_en    <= (cpu_we && !cpu_bad) ? cpu_en_enc : 4'b0000;
              mem_wdata <= (cpu_we && !cpu_bad) ? cpu_wd_enc : 32'h0;
            end
          end
        end
        S_ACCESS: begin
          mem_addr  <= '0;
          mem_wdata <= 32'h0;
          mem_en    <= 4'b0000;
          mem_rd    <= 1'b0;
          if (is_read && !is_err) begin
            state <= S_RDWAIT;
          end else begin
            state <= S_DONE;
            if (gnt_dma) begin
              dma_done <= 1'b1;
            end else begin
              cpu_ready <= 1'b1;
              cpu_err   <= is_err;
            end
          end
        end
        S_RDWAIT: begin
          state <= S_DONE;
          if (gnt_dma) begin
            dma_rdata <= mem_rdata;
            dma_done  <= 1'b1;
          end else begin
            cpu_rdata <= mem_rdata;
            cpu_ready <= 1'b1;
            cpu_err   <= 1'b0;
          end
        end
        S_DONE: begin
          cpu_ready <= 1'b0;
          cpu_err   <= 1'b0;
          dma_done  <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - directed table-driven bench for data_mem_arbiter
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [1:0]  cpu_size;
  logic        cpu_ready, cpu_err;
  logic [31:0] cpu_rdata;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_done;
  logic [31:0] dma_rdata;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_en;
  logic        mem_rd;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:1023];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [9:0]  e_addr;
    logic [3:0]  e_en;
    logic [31:0] e_wdata;
    logic        e_rd;
    logic        e_err;
    int          e_lat;
    logic [31:0] e_rdata;
    logic        chk_rdata;
  } vec_t;

  vec_t vecs [13];

  data_mem_arbiter #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_size(cpu_size), .cpu_ready(cpu_ready), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_done(dma_done), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_en(mem_en), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory model: per-lane writes, read data one cycle after mem_rd
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[8]    <= 32'hCAFEF00D;
      mem[32]   <= 32'h11223344;
      mem_rdata <= 32'h0;
    end else begin
      if (mem_rd) mem_rdata <= mem[mem_addr];
      for (int k = 0; k < 4; k++)
        if (mem_en[k]) mem[mem_addr][31-8*k -: 8] <= mem_wdata[31-8*k -: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cpu_txn(input int idx, input vec_t v);
    int lat;
    cpu_req   = 1'b1;
    cpu_we    = v.we;
    cpu_addr  = v.addr;
    cpu_wdata = v.wdata;
    cpu_size  = v.size;
    @(posedge clk); #1;
    chk($sformatf("v%0d mem_en", idx), {28'h0, mem_en}, {28'h0, v.e_en});
    chk($sformatf("v%0d mem_rd", idx), {31'h0, mem_rd}, {31'h0, v.e_rd});
    chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.e_wdata);
    if (!v.e_err) chk($sformatf("v%0d mem_addr", idx), {22'h0, mem_addr}, {22'h0, v.e_addr});
    chk($sformatf("v%0d early_ready", idx), {31'h0, cpu_ready}, 32'h0);
    lat = 0;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      if (cpu_ready) begin
        lat = c;
        break;
      end
    end
    chk($sformatf("v%0d latency", idx), lat, v.e_lat);
    chk($sformatf("v%0d cpu_err", idx), {31'h0, cpu_err}, {31'h0, v.e_err});
    if (v.chk_rdata) chk($sformatf("v%0d cpu_rdata", idx), cpu_rdata, v.e_rdata);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("v%0d pulse_end", idx), {31'h0, cpu_ready}, 32'h0);
  endtask

  initial begin
    int n;
    int lat;
    logic [3:0] order;
    logic overlap;
    logic rd_ok;

    //          we    addr          wdata         sz     eaddr   een      ewdata        erd   eerr  lat rdata         chk
    vecs[0]  = '{1'b1, 32'h00000010, 32'hDEADBEEF, 2'b00, 10'd4,  4'b1111, 32'hDEADBEEF, 1'b0, 1'b0, 1, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 32'h00000012, 32'h000000A5, 2'b10, 10'd4,  4'b0100, 32'h0000A500, 1'b0, 1'b0, 1, 32'h0,        1'b0};
    vecs[2]  = '{1'b1, 32'h00000012, 32'h00001234, 2'b01, 10'd4,  4'b1100, 32'h00001234, 1'b0, 1'b0, 1, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 32'h00000011, 32'h00001234, 2'b01, 10'd4,  4'b0000, 32'h0,        1'b0, 1'b1, 1, 32'h0,        1'b1};
    vecs[4]  = '{1'b0, 32'h00000020, 32'h0,        2'b11, 10'd8,  4'b0000, 32'h0,        1'b0, 1'b1, 1, 32'h0,        1'b1};
    vecs[5]  = '{1'b0, 32'h00000020, 32'h0,        2'b00, 10'd8,  4'b0000, 32'h0,        1'b1, 1'b0, 2, 32'hCAFEF00D, 1'b1};
    vecs[6]  = '{1'b1, 32'h00000023, 32'hFFFFFF77, 2'b10, 10'd8,  4'b1000, 32'h00000077, 1'b0, 1'b0, 1, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 32'h00000021, 32'h0,        2'b10, 10'd8,  4'b0000, 32'h0,        1'b1, 1'b0, 2, 32'hCAFEF077, 1'b1};
    vecs[8]  = '{1'b1, 32'h00000040, 32'hFFFFABCD, 2'b01, 10'd16, 4'b0011, 32'hABCD0000, 1'b0, 1'b0, 1, 32'h0,        1'b0};
    vecs[9]  = '{1'b1, 32'h00000030, 32'hFFFFFF5A, 2'b10, 10'd12, 4'b0001, 32'h5A000000, 1'b0, 1'b0, 1, 32'h0,        1'b0};
    vecs[10] = '{1'b1, 32'h00001017, 32'h13579BDF, 2'b00, 10'd5,  4'b1111, 32'h13579BDF, 1'b0, 1'b0, 1, 32'h0,        1'b0};
    vecs[11] = '{1'b0, 32'h00000023, 32'h0,        2'b01, 10'd8,  4'b0000, 32'h0,        1'b0, 1'b1, 1, 32'hCAFEF077, 1'b1};
    vecs[12] = '{1'b0, 32'h00000012, 32'h0,        2'b01, 10'd4,  4'b0000, 32'h0,        1'b1, 1'b0, 2, 32'hDEAD1234, 1'b1};

    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_size = 2'b00;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs",
        {cpu_ready, cpu_err, dma_done, mem_rd, mem_en, 22'h0, mem_addr},
        32'h0);
    chk("reset cpu_rdata", cpu_rdata, 32'h0);
    chk("reset dma_rdata", dma_rdata, 32'h0);
    chk("reset mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) cpu_txn(i, vecs[i]);

    // Both requesters held from reset: CPU store, DMA read; grants must alternate
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h00000100; cpu_wdata = 32'h1; cpu_size = 2'b00;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h00000080;
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    order = 4'b0;
    overlap = 1'b0;
    rd_ok = 1'b1;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(posedge clk); #1;
      if (mem_rd && mem_en != 4'b0000) overlap = 1'b1;
      if (cpu_ready && dma_done) overlap = 1'b1;
      if (cpu_ready) begin
        order[n] = 1'b0;
        n++;
      end else if (dma_done) begin
        order[n] = 1'b1;
        if (dma_rdata !== 32'h11223344) rd_ok = 1'b0;
        n++;
      end
    end
    chk("rr completions", n, 4);
    chk("rr grant order", {28'h0, order}, {28'h0, 4'b1010});
    chk("rr no overlap", {31'h0, overlap}, 32'h0);
    chk("rr dma_rdata", {31'h0, rd_ok}, 32'h1);
    cpu_req = 1'b0;
    dma_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset during ACCESS of a DMA write, request held through it
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h00000084; dma_wdata = 32'h55AA55AA;
    @(posedge clk); #1;
    chk("abort access mem_en", {28'h0, mem_en}, 32'hF);
    chk("abort access mem_addr", {22'h0, mem_addr}, 32'd33);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort outputs", {cpu_ready, cpu_err, dma_done, mem_rd, mem_en, 22'h0, mem_addr}, 32'h0);
    chk("abort mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    lat = 0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (dma_done) begin
        lat = c;
        break;
      end
    end
    chk("regrant latency", lat, 2);
    chk("regrant mem write", mem[33], 32'h55AA55AA);
    dma_req = 1'b0;
    @(posedge clk); #1;
    chk("regrant pulse_end", {31'h0, dma_done}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Sequencing controller and two-way arbiter for the single data-memory port. It serialises CPU loads/stores and DMA word transfers onto one port, applies the byte-lane write encoding for sub-word stores, and rejects misaligned accesses. It sits between the CPU memory stage and DMA engine on one side and the data memory on the other.

## Interface
- `ADDR_W`, 10, data-memory word-address width; `mem_addr` = byte address bits [ADDR_W+1:2].
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cpu_req` in 1: CPU access request, held until `cpu_ready`.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_addr` in 32: byte address.
- `cpu_wdata` in 32: store data, right-justified.
- `cpu_size` in 2: 00 word, 01 halfword, 10 byte, 11 reserved.
- `cpu_ready` out 1: one-cycle completion pulse.
- `cpu_err` out 1: valid with `cpu_ready`; 1 = access rejected.
- `cpu_rdata` out 32: raw memory word for a load, valid with `cpu_ready`.
- `dma_req`, `dma_we` in 1: DMA request and direction (word-only).
- `dma_addr` in 32, `dma_wdata` in 32: byte address (bits [1:0] ignored), write data.
- `dma_done` out 1: one-cycle completion pulse.
- `dma_rdata` out 32: read word, valid with `dma_done`.
- `mem_addr` out ADDR_W, `mem_wdata` out 32, `mem_en` out 4, `mem_rd` out 1: memory port; `mem_en` per-lane write enables.
- `mem_rdata` in 32: read data, valid the cycle after `mem_rd`.

## Operation
- States: IDLE, ACCESS, RDWAIT, DONE. `last` flag records last granted requester.
- IDLE: no request -> stay. One request -> grant it. Both -> grant the one not equal to `last` (round-robin). On grant: latch requester, register memory-port outputs, update `last`, go ACCESS.
- ACCESS: memory outputs held one cycle. Write or error -> DONE. Valid read -> RDWAIT.
- RDWAIT: capture `mem_rdata` into granted requester's rdata register -> DONE.
- DONE: pulse `cpu_ready`(+`cpu_err`) or `dma_done` -> IDLE.
- Lane k (`mem_en[k]`) = data bits [31-8k:24-8k]; offset = addr[1:0].
- Word (size 00): offset ignored, `mem_en`=1111, data unchanged.
- Halfword: offset 00 -> `mem_en`=0011, data {wdata[15:0],16'h0}; offset 10 -> 1100, {16'h0,wdata[15:0]}; offset 01/11 -> error.
- Byte: offset n -> `mem_en`=1<<n, wdata[7:0] placed in lane n, other lanes 0.
- Error (misaligned halfword or size 11, load or store): ACCESS issues `mem_en`=0000, `mem_rd`=0; DONE asserts `cpu_ready` and `cpu_err`; `cpu_rdata` unchanged.
- Loads of any size read the full word (`mem_rd`=1, `mem_en`=0000); lane extraction/sign-extension is downstream.
- DMA: always word, `mem_en`=1111 for writes, never errors.
- Memory outputs are 0 in every state except ACCESS; `mem_addr`/`mem_wdata` also 0 outside ACCESS.

## Timing
- Reset: state IDLE, `last`=DMA (CPU wins first tie), all outputs 0 (`cpu_ready`, `cpu_err`, `cpu_rdata`, `dma_done`, `dma_rdata`, `mem_*`).
- Reset mid-operation: next cycle IDLE, no `mem_en`/`mem_rd`, no completion pulse; the aborted request is re-arbitrated if still held.
- Write/error latency: request sampled edge 0 -> ACCESS cycle 1 -> completion pulse cycle 2.
- Read latency: ACCESS cycle 1 -> RDWAIT cycle 2 -> pulse with data cycle 3.
- Request inputs are sampled only in IDLE; changes during ACCESS/RDWAIT/DONE are ignored.
- Requester deasserts or replaces its request on the edge ending the completion pulse; IDLE in the following cycle arbitrates afresh.
- Back-to-back: minimum 3 cycles per write, 4 per read (one IDLE cycle between transactions).
- Losing requester waits; with both continuously requesting, grants alternate strictly.

## Test plan
- Reset then CPU store word 0xDEADBEEF at 0x0000_0010 -> cycle 1 `mem_addr`=4, `mem_en`=1111, `mem_wdata`=0xDEADBEEF; cycle 2 `cpu_ready`=1, `cpu_err`=0.
- CPU byte store 0x0000_00A5 at offset 2 -> `mem_en`=0100, `mem_wdata`=0x0000_A500; halfword 0x1234 at offset 2 -> 1100, 0x0000_1234.
- CPU halfword store at offset 01 and load with size 11 -> `mem_en`=0000, `mem_rd`=0, `cpu_ready`=`cpu_err`=1 at cycle 2.
- CPU load 0x20 with memory word 0xCAFEF00D -> `mem_rd`=1 cycle 1, `cpu_ready`=1 and `cpu_rdata`=0xCAFEF00D cycle 3.
- `cpu_req` and `dma_req` both held high from reset for 4 transactions -> grant order CPU, DMA, CPU, DMA; no overlap of `mem_en`/`mem_rd`.
- `rst` asserted during ACCESS of a DMA write -> next cycle all outputs 0, no `dma_done`; held `dma_req` then re-granted and completes normally.
